// File: rtl/intdiv_iter_pkg.sv
// intdiv_iter_pkg: shared definitions for the iterative integer divider.
//   - funct3 encodings of the M-extension divide/remainder operations
//   - state type of the divider control FSM
package intdiv_iter_pkg;

    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        ITER,
        FIXUP,
        DONE
    } divstate_t;

endpackage

// File: rtl/intdiv_step.sv
// intdiv_step: one combinational restoring-division step.
//   prem     - partial remainder (always below the divisor)
//   divisor  - divisor magnitude, zero-extended to XLEN+1 bits
//   dbit     - next dividend bit shifted into the remainder
//   rem_next - partial remainder after the trial subtraction
//   qbit     - quotient bit produced by this step
module intdiv_step #(
    parameter int XLEN = 64
) (
    input  logic [XLEN:0] prem,
    input  logic [XLEN:0] divisor,
    input  logic          dbit,
    output logic [XLEN:0] rem_next,
    output logic          qbit
);

    logic [XLEN+1:0] shifted;
    logic [XLEN+1:0] diff;

    // One guard bit above the shifted remainder makes the top bit of the
    // difference a clean borrow/sign indicator.
    assign shifted  = {prem, dbit};
    assign diff     = shifted - {1'b0, divisor};
    assign qbit     = ~diff[XLEN+1];
    assign rem_next = qbit ? diff[XLEN:0] : shifted[XLEN:0];

endmodule

// File: rtl/intdiv_iter.sv
// intdiv_iter: multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU
// and, when XLEN=64, the word forms DIVW/DIVUW/REMW/REMUW.
//   clk, reset_n       - clock, asynchronous active-low reset
//   StartE, FlushE     - request / abort from the Execute stage
//   Funct3E, W64E      - operation select and word-operation flag
//   ForwardedSrcAE/BE  - dividend / divisor
//   ReadyE             - idle, a request is taken this cycle
//   BusyE              - divide in progress (stall request)
//   DoneM, ResultM     - result valid and value, held until ResultAckM
//   ResultAckM         - writeback consumes the result
module intdiv_iter
    import intdiv_iter_pkg::*;
#(
    parameter int XLEN        = 64,
    parameter int W_SUPPORTED = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            StartE,
    input  logic            FlushE,
    input  logic [2:0]      Funct3E,
    input  logic            W64E,
    input  logic [XLEN-1:0] ForwardedSrcAE,
    input  logic [XLEN-1:0] ForwardedSrcBE,
    output logic            ReadyE,
    output logic            BusyE,
    output logic            DoneM,
    input  logic            ResultAckM,
    output logic [XLEN-1:0] ResultM
);

    localparam int CNT_W   = $clog2(XLEN);
    localparam bit WORD_OK = (W_SUPPORTED != 0) && (XLEN == 64);

    divstate_t        state, state_next;
    logic [2:0]       funct;
    logic             word;
    logic [XLEN-1:0]  a_raw, b_raw;
    logic [XLEN-1:0]  q;
    logic [XLEN:0]    rem, dvsr;
    logic [CNT_W-1:0] count;
    logic             neg_q, neg_r;
    logic [XLEN-1:0]  result;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        logic signed [31:0]      lo;
        logic signed [XLEN-1:0]  ext;
        lo  = v;
        ext = lo;
        return ext;
    endfunction

    function automatic logic [XLEN-1:0] zext32(input logic [31:0] v);
        return XLEN'(v);
    endfunction

    // Word results are always sign-extended from bit 31, unsigned forms included.
    function automatic logic [XLEN-1:0] wordfix(input logic w, input logic [XLEN-1:0] v);
        return w ? sext32(v[31:0]) : v;
    endfunction

    // Operand conditioning, used in PREP from the latched request.
    logic             op_unsigned, op_rem;
    logic [XLEN-1:0]  a_ext, b_ext, a_mag, b_mag, most_neg;
    logic             a_neg, b_neg, div0, ovf, special;
    logic [XLEN-1:0]  q_fix, r_fix;

    assign op_unsigned = (funct == F3_DIVU) || (funct == F3_REMU);
    assign op_rem      = (funct == F3_REM)  || (funct == F3_REMU);

    assign a_ext = word ? (op_unsigned ? zext32(a_raw[31:0]) : sext32(a_raw[31:0])) : a_raw;
    assign b_ext = word ? (op_unsigned ? zext32(b_raw[31:0]) : sext32(b_raw[31:0])) : b_raw;

    assign a_neg = ~op_unsigned & a_ext[XLEN-1];
    assign b_neg = ~op_unsigned & b_ext[XLEN-1];
    assign a_mag = a_neg ? -a_ext : a_ext;
    assign b_mag = b_neg ? -b_ext : b_ext;

    assign most_neg = word ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
    assign div0     = (b_ext == '0);
    assign ovf      = ~op_unsigned & (a_ext == most_neg) & (b_ext == '1);
    assign special  = div0 | ovf;

    assign q_fix = neg_q ? -q : q;
    assign r_fix = neg_r ? -rem[XLEN-1:0] : rem[XLEN-1:0];

    logic [XLEN:0] rem_next;
    logic          qbit;

    intdiv_step #(.XLEN(XLEN)) u_step (
        .prem     (rem),
        .divisor  (dvsr),
        .dbit     (q[XLEN-1]),
        .rem_next (rem_next),
        .qbit     (qbit)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ReadyE     = 1'b0;
        BusyE      = 1'b0;
        DoneM      = 1'b0;
        case (state)
            IDLE: begin
                ReadyE = 1'b1;
                if (StartE) state_next = PREP;
            end
            PREP: begin
                BusyE      = 1'b1;
                state_next = special ? DONE : ITER;
            end
            ITER: begin
                BusyE = 1'b1;
                if (count == '0) state_next = FIXUP;
            end
            FIXUP: begin
                BusyE      = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                DoneM = 1'b1;
                if (ResultAckM) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // Flush overrides everything, including an accept or an acknowledge.
        if (FlushE) state_next = IDLE;
    end

    assign ResultM = result;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            funct  <= '0;
            word   <= 1'b0;
            a_raw  <= '0;
            b_raw  <= '0;
            q      <= '0;
            rem    <= '0;
            dvsr   <= '0;
            count  <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (StartE && !FlushE) begin
                        a_raw <= ForwardedSrcAE;
                        b_raw <= ForwardedSrcBE;
                        funct <= Funct3E;
                        word  <= W64E & WORD_OK;
                    end
                end
                PREP: begin
                    neg_q <= a_neg ^ b_neg;
                    neg_r <= a_neg;
                    rem   <= '0;
                    dvsr  <= {1'b0, b_mag};
                    // Word dividends are left-justified so the step always
                    // consumes from the top bit; 32 shifts leave the quotient
                    // in the low half with the upper half cleared.
                    q     <= word ? (a_mag << (XLEN-32)) : a_mag;
                    count <= word ? CNT_W'(31) : CNT_W'(XLEN-1);
                    if (special) begin
                        result <= wordfix(word, op_rem ? (div0 ? a_ext : '0)
                                                       : (div0 ? '1 : a_ext));
                    end
                end
                ITER: begin
                    rem   <= rem_next;
                    q     <= {q[XLEN-2:0], qbit};
                    count <= count - 1'b1;
                end
                FIXUP: begin
                    result <= wordfix(word, op_rem ? r_fix : q_fix);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_intdiv_iter.sv
module tb_intdiv_iter;

    logic        clk;
    logic        reset_n;
    logic        StartE;
    logic        FlushE;
    logic [2:0]  Funct3E;
    logic        W64E;
    logic [63:0] ForwardedSrcAE;
    logic [63:0] ForwardedSrcBE;
    logic        ReadyE;
    logic        BusyE;
    logic        DoneM;
    logic        ResultAckM;
    logic [63:0] ResultM;

    intdiv_iter #(.XLEN(64), .W_SUPPORTED(1)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .StartE         (StartE),
        .FlushE         (FlushE),
        .Funct3E        (Funct3E),
        .W64E           (W64E),
        .ForwardedSrcAE (ForwardedSrcAE),
        .ForwardedSrcBE (ForwardedSrcBE),
        .ReadyE         (ReadyE),
        .BusyE          (BusyE),
        .DoneM          (DoneM),
        .ResultAckM     (ResultAckM),
        .ResultM        (ResultM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected-transaction record shared with the compare process.
    bit          t_act  = 1'b0;
    bit          chk_en = 1'b0;
    int          t_acc, t_lat, t_end;
    logic [63:0] t_res;

    localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: plain integer arithmetic on the architectural operands.
    task automatic model(input logic [2:0] f, input logic w, input logic [63:0] a,
                         input logic [63:0] b, output logic [63:0] res, output int lat);
        bit          sgn;
        bit          ovf;
        int          ti;
        longint      tl, sx, sy;
        logic [63:0] x, y, qq, rr, mn;
        sgn = (f == DIV) || (f == REM);
        if (w) begin
            if (sgn) begin
                ti = a[31:0]; tl = ti; x = tl;
                ti = b[31:0]; tl = ti; y = tl;
            end else begin
                x = {32'b0, a[31:0]};
                y = {32'b0, b[31:0]};
            end
            mn = 64'hFFFF_FFFF_8000_0000;
        end else begin
            x  = a;
            y  = b;
            mn = 64'h8000_0000_0000_0000;
        end
        ovf = sgn && (x == mn) && (y == 64'hFFFF_FFFF_FFFF_FFFF);
        if (y == 64'd0) begin
            qq = 64'hFFFF_FFFF_FFFF_FFFF;
            rr = x;
        end else if (ovf) begin
            qq = x;
            rr = 64'd0;
        end else if (sgn) begin
            sx = x; sy = y;
            tl = sx / sy; qq = tl;
            tl = sx % sy; rr = tl;
        end else begin
            qq = x / y;
            rr = x % y;
        end
        res = f[1] ? rr : qq;
        if (w) begin
            ti = res[31:0]; tl = ti; res = tl;
        end
        lat = ((y == 64'd0) || ovf) ? 2 : ((w ? 32 : 64) + 3);
    endtask

    // Cycle-by-cycle comparison against the expected transaction.
    always @(negedge clk) begin
        int   k;
        logic er, eb, ed;
        if (chk_en && reset_n) begin
            er = 1'b1; eb = 1'b0; ed = 1'b0;
            if (t_act) begin
                k = cyc - t_acc;
                if (k <= t_end - t_acc) begin
                    er = (k == 0);
                    eb = (k >= 1) && (k < t_lat);
                    ed = (k >= t_lat);
                end
            end
            check("ReadyE", {63'b0, ReadyE}, {63'b0, er});
            check("BusyE",  {63'b0, BusyE},  {63'b0, eb});
            check("DoneM",  {63'b0, DoneM},  {63'b0, ed});
            if (ed) check("ResultM", ResultM, t_res);
        end
    end

    task automatic run_op(input string tag, input logic [2:0] f, input logic w,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp_lit, input int lat_lit,
                          input int hold, input bit poke, input bit nowait);
        logic [63:0] mres;
        int          mlat;
        int          g;
        model(f, w, a, b, mres, mlat);
        check({"model_res_", tag}, mres, exp_lit);
        check({"model_lat_", tag}, 64'(mlat), 64'(lat_lit));
        if (!nowait) begin
            @(posedge clk); #1;
        end
        StartE = 1'b1; Funct3E = f; W64E = w;
        ForwardedSrcAE = a; ForwardedSrcBE = b;
        t_acc = cyc; t_lat = mlat; t_res = mres; t_end = 32'h3FFF_FFFF; t_act = 1'b1;
        @(posedge clk); #1;
        StartE = 1'b0;
        ForwardedSrcAE = ~a; ForwardedSrcBE = ~b;
        if (poke) begin
            while (cyc - t_acc < 5) begin
                @(posedge clk); #1;
            end
            StartE = 1'b1; Funct3E = DIVU; ForwardedSrcAE = 64'd50; ForwardedSrcBE = 64'd5;
            @(posedge clk); #1;
            StartE = 1'b0;
        end
        g = 0;
        while (DoneM !== 1'b1 && g < 200) begin
            @(posedge clk); #1;
            g++;
        end
        check({"done_seen_", tag}, {63'b0, DoneM}, 64'd1);
        check({"latency_", tag}, 64'(cyc - t_acc), 64'(lat_lit));
        check({"result_", tag}, ResultM, exp_lit);
        repeat (hold) begin
            @(posedge clk); #1;
        end
        if (hold > 0) begin
            check({"held_done_", tag}, {63'b0, DoneM}, 64'd1);
            check({"held_res_", tag}, ResultM, exp_lit);
        end
        ResultAckM = 1'b1;
        if (poke) begin
            StartE = 1'b1; Funct3E = DIVU; ForwardedSrcAE = 64'd77; ForwardedSrcBE = 64'd7;
        end
        t_end = cyc;
        @(posedge clk); #1;
        ResultAckM = 1'b0;
        StartE     = 1'b0;
        check({"ack_ready_", tag}, {63'b0, ReadyE}, 64'd1);
        check({"ack_busy_", tag},  {63'b0, BusyE},  64'd0);
        t_act = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        reset_n = 1'b0; StartE = 1'b0; FlushE = 1'b0; Funct3E = DIVU; W64E = 1'b0;
        ForwardedSrcAE = '0; ForwardedSrcBE = '0; ResultAckM = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready",  {63'b0, ReadyE}, 64'd1);
        check("rst_busy",   {63'b0, BusyE},  64'd0);
        check("rst_done",   {63'b0, DoneM},  64'd0);
        check("rst_result", ResultM,         64'd0);
        reset_n = 1'b1;
        chk_en  = 1'b1;

        run_op("divu_100_7", DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 67, 0, 1'b1, 1'b0);
        run_op("remu_100_7", REMU, 1'b0, 64'd100, 64'd7, 64'd2, 67, 0, 1'b0, 1'b0);
        run_op("div_m7_2", DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
               64'hFFFF_FFFF_FFFF_FFFD, 67, 0, 1'b0, 1'b0);
        run_op("rem_m7_2", REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
               64'hFFFF_FFFF_FFFF_FFFF, 67, 0, 1'b0, 1'b0);
        run_op("rem_7_m2", REM, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 67, 0, 1'b0, 1'b0);
        run_op("divu_5_0", DIVU, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 2, 0, 1'b0, 1'b0);
        run_op("rem_5_0", REM, 1'b0, 64'd5, 64'd0, 64'd5, 2, 0, 1'b0, 1'b0);
        run_op("div_ovf", DIV, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
               64'h8000_0000_0000_0000, 2, 0, 1'b0, 1'b0);
        run_op("rem_ovf", REM, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
               64'd0, 2, 0, 1'b0, 1'b0);
        run_op("divw_ovf", DIV, 1'b1, 64'h0000_0001_8000_0000, 64'h0000_0000_FFFF_FFFF,
               64'hFFFF_FFFF_8000_0000, 2, 0, 1'b0, 1'b0);
        run_op("divuw", DIVU, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd2,
               64'h0000_0000_7FFF_FFFF, 35, 0, 1'b0, 1'b0);
        run_op("remuw", REMU, 1'b1, 64'hDEAD_0000_FFFF_FFFF, 64'h1234_0000_0000_0010,
               64'd15, 35, 0, 1'b0, 1'b0);
        run_op("remw_m7_2", REM, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2,
               64'hFFFF_FFFF_FFFF_FFFF, 35, 0, 1'b0, 1'b0);
        run_op("div_max_3", DIV, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd3,
               64'h2AAA_AAAA_AAAA_AAAA, 67, 0, 1'b0, 1'b0);
        run_op("divu_ones_1", DIVU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,
               64'hFFFF_FFFF_FFFF_FFFF, 67, 0, 1'b0, 1'b0);
        run_op("hold_div", DIV, 1'b0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9,
               64'hFFFF_FFFF_FFFF_FFF2, 67, 20, 1'b0, 1'b0);

        // Flush in the middle of an iteration, then a new request right after.
        @(posedge clk); #1;
        StartE = 1'b1; Funct3E = DIVU; W64E = 1'b0;
        ForwardedSrcAE = 64'd1000; ForwardedSrcBE = 64'd3;
        t_acc = cyc; t_lat = 67; t_res = 64'd333; t_end = 32'h3FFF_FFFF; t_act = 1'b1;
        base = cyc;
        @(posedge clk); #1;
        StartE = 1'b0;
        while (cyc - base < 10) begin
            @(posedge clk); #1;
        end
        FlushE = 1'b1;
        t_end  = cyc;
        @(posedge clk); #1;
        FlushE = 1'b0;
        check("flush_ready", {63'b0, ReadyE}, 64'd1);
        check("flush_done",  {63'b0, DoneM},  64'd0);
        check("flush_cycle", 64'(cyc - base), 64'd11);
        run_op("divu_9_3", DIVU, 1'b0, 64'd9, 64'd3, 64'd3, 67, 0, 1'b0, 1'b1);
        check("flush_restart_done", 64'(t_end - base), 64'd78);

        // Asynchronous reset in the middle of an iteration.
        @(posedge clk); #1;
        StartE = 1'b1; Funct3E = DIVU; W64E = 1'b0;
        ForwardedSrcAE = 64'd100; ForwardedSrcBE = 64'd7;
        t_acc = cyc; t_lat = 67; t_res = 64'd14; t_end = 32'h3FFF_FFFF; t_act = 1'b1;
        @(posedge clk); #1;
        StartE = 1'b0;
        while (cyc - t_acc < 20) begin
            @(posedge clk); #1;
        end
        check("pre_reset_busy", {63'b0, BusyE}, 64'd1);
        #2;
        chk_en  = 1'b0;
        t_act   = 1'b0;
        reset_n = 1'b0;
        #1;
        check("async_rst_ready",  {63'b0, ReadyE}, 64'd1);
        check("async_rst_busy",   {63'b0, BusyE},  64'd0);
        check("async_rst_done",   {63'b0, DoneM},  64'd0);
        check("async_rst_result", ResultM,         64'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b1;
        chk_en  = 1'b1;
        run_op("after_reset", DIVU, 1'b0, 64'd81, 64'd9, 64'd9, 67, 0, 1'b0, 1'b0);

        @(posedge clk); #1;
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
